// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF delay layer: FSM states, weight bit
// positions and the saturating membrane update.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int W_ACTIVE = 0;
    localparam int W_INHIB  = 1;

    // 32-bit arithmetic has ample headroom, so mem + sum - decay never wraps
    // before the clamp to [0, max_val].
    function automatic int sat_update(input int mem, input int sum,
                                      input int leak, input int max_val);
        int t;
        t = mem + sum - leak;
        if (t < 0) return 0;
        if (t > max_val) return max_val;
        return t;
    endfunction

endpackage

// File: rtl/snn_spike_history.sv
// Per-input spike history shift register; slot k holds the spike sampled k
// ticks before the most recent delay_tick.
module snn_spike_history
    import snn_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             delay_tick,
    input  logic             spike_in,
    output logic [DEPTH-1:0] hist
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
        end else if (enable && delay_tick) begin
            hist <= {hist[DEPTH-2:0], spike_in};
        end
    end

endmodule

// File: rtl/snn_delay_layer.sv
// Single LIF layer with per-synapse axonal delays; neurons are updated one per
// cycle through a shared adder tree.
//   state | meaning
//   IDLE  | waiting for step; synapse inputs snapshotted on accept
//   RUN   | updating neuron idx, one per cycle
//   DONE  | timestep complete, output_data_ready high
module snn_delay_layer
    import snn_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int MEM_W = 6,
    parameter int DLY_W = 3,
    parameter int DEC_W = 3,
    parameter int REF_W = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         step,
    input  logic                         delay_tick,
    input  logic [N_IN-1:0]              input_spikes,
    input  logic [N_OUT*N_IN*2-1:0]      weights,
    input  logic [N_OUT*N_IN*(DLY_W+1)-1:0] delays,
    input  logic [MEM_W-1:0]             threshold,
    input  logic [DEC_W-1:0]             decay,
    input  logic [REF_W-1:0]             refractory_period,
    output logic [N_OUT*MEM_W-1:0]       membrane_potential_out,
    output logic [N_OUT-1:0]             output_spikes,
    output logic                         busy,
    output logic                         output_data_ready
);

    localparam int DEPTH   = 1 << DLY_W;
    localparam int N_SYN   = N_OUT * N_IN;
    localparam int SUM_W   = $clog2(N_IN + 1) + 1;
    localparam int IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int MEM_MAX = (1 << MEM_W) - 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_OUT - 1);
    localparam logic signed [SUM_W-1:0] ONE      = SUM_W'(1);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic                    accept;
    logic [DEPTH-1:0]        hist [N_IN];
    logic [N_SYN-1:0]        syn_in, snap;
    logic [DLY_W:0]          dfield;
    logic [1:0]              wfield;
    logic signed [SUM_W-1:0] sum;
    logic [MEM_W-1:0]        clamped;
    logic [MEM_W-1:0]        mem_q [N_OUT];
    logic [REF_W-1:0]        ref_cnt [N_OUT];

    for (genvar i = 0; i < N_IN; i++) begin : g_hist
        snn_spike_history #(.DEPTH(DEPTH)) u_hist (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .delay_tick (delay_tick),
            .spike_in   (input_spikes[i]),
            .hist       (hist[i])
        );
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_mem_out
        assign membrane_potential_out[j*MEM_W +: MEM_W] = mem_q[j];
    end

    always_comb begin
        syn_in = '0;
        dfield = '0;
        for (int s = 0; s < N_SYN; s++) begin
            dfield    = delays[s*(DLY_W+1) +: DLY_W+1];
            syn_in[s] = dfield[DLY_W] ? hist[s % N_IN][dfield[DLY_W-1:0]]
                                      : input_spikes[s % N_IN];
        end
    end

    // Shared adder tree, steered to the neuron currently being updated.
    always_comb begin
        sum    = '0;
        wfield = '0;
        for (int i = 0; i < N_IN; i++) begin
            wfield = weights[(int'(idx)*N_IN + i)*2 +: 2];
            if (snap[int'(idx)*N_IN + i] && wfield[W_ACTIVE])
                sum = wfield[W_INHIB] ? sum - ONE : sum + ONE;
        end
    end

    assign clamped = MEM_W'(sat_update(int'(mem_q[idx]), int'(sum),
                                       int'(decay), MEM_MAX));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        if (enable) begin
            case (state)
                IDLE: if (step) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                    accept    = 1'b1;
                end
                RUN: begin
                    if (idx == LAST_IDX) state_nxt = DONE;
                    else                 idx_nxt   = idx + IDX_W'(1);
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            idx               <= '0;
            busy              <= 1'b0;
            output_data_ready <= 1'b0;
        end else if (enable) begin
            state             <= state_nxt;
            idx               <= idx_nxt;
            busy              <= (state_nxt != IDLE);
            output_data_ready <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap          <= '0;
            output_spikes <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                mem_q[j]   <= '0;
                ref_cnt[j] <= '0;
            end
        end else if (enable) begin
            if (accept) snap <= syn_in;
            if (state == RUN) begin
                if (ref_cnt[idx] != '0) begin
                    ref_cnt[idx]       <= ref_cnt[idx] - REF_W'(1);
                    mem_q[idx]         <= '0;
                    output_spikes[idx] <= 1'b0;
                end else if (clamped >= threshold) begin
                    ref_cnt[idx]       <= refractory_period;
                    mem_q[idx]         <= '0;
                    output_spikes[idx] <= 1'b1;
                end else begin
                    mem_q[idx]         <= clamped;
                    output_spikes[idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/snn_delay_layer.md
# snn_delay_layer

Parametrised single-layer leaky-integrate-and-fire (LIF) spiking layer with per-synapse programmable axonal delays. It is the generalised successor of the fixed 8-input, two-layer delay network top. Layers are built by chaining instances: the `output_spikes` of one instance drive the `input_spikes` of the next. Neurons are updated one per cycle by a sequencer, which trades latency for a single shared adder tree per layer.

## Interface

Parameters:

- N_IN, 8, number of input spike channels
- N_OUT, 8, number of neurons
- MEM_W, 6, membrane potential and threshold width
- DLY_W, 3, delay value width; history depth is 2^DLY_W
- DEC_W, 3, decay width
- REF_W, 5, refractory counter width

Ports:

- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- enable  in  1  global enable; when low, all state freezes
- step  in  1  start-of-timestep strobe
- delay_tick  in  1  delay-line shift strobe, synchronous to clk
- input_spikes  in  N_IN  input spikes
- weights  in  N_OUT\*N_IN\*2  weight field of synapse s=j\*N_IN+i at [s\*2+:2]; bit0=active, bit1=inhibitory
- delays  in  N_OUT\*N_IN\*(DLY_W+1)  delay field of synapse s at [s\*(DLY_W+1)+:DLY_W+1]; low DLY_W bits=value d, MSB=delay enable
- threshold  in  MEM_W  firing threshold
- decay  in  DEC_W  leak subtracted per timestep
- refractory_period  in  REF_W  refractory timesteps after a spike
- membrane_potential_out  out  N_OUT\*MEM_W  neuron j at [j\*MEM_W+:MEM_W]
- output_spikes  out  N_OUT  spike of neuron j from the last timestep
- busy  out  1  high in RUN and DONE
- output_data_ready  out  1  one-cycle pulse when a timestep completes

## Operation

- History: each input i has a shift register hist_i[0..2^DLY_W-1].
  - On delay_tick with enable high: hist_i[0] <= input_spikes[i] and hist_i[k] <= hist_i[k-1].
  - Ticks run independently of the FSM.
- Synapse input for synapse (j,i):
  - delay enable = 1: the synapse input is hist_i[d].
  - delay enable = 0: the synapse input is input_spikes[i].
- Snapshot: when a step is accepted, all N_OUT\*N_IN synapse inputs are latched. If delay_tick arrives in the same cycle, the snapshot uses the pre-shift history.
- Contribution of each synapse: +1 if active and excitatory, -1 if active and inhibitory, 0 if inactive.
- The synaptic sum S_j is signed, with width ceil(log2(N_IN+1))+1.
- FSM states:
  - IDLE: step && enable → RUN, idx=0.
  - RUN: update neuron idx, then idx++. After the update of idx=N_OUT-1 → DONE.
  - DONE: output_data_ready=1 → IDLE.
- Neuron update, non-refractory case (ref_cnt_j==0):
  - t = mem_j + S_j − decay, computed signed at MEM_W+2 bits.
  - Clamp t to [0, 2^MEM_W−1].
  - If clamped t ≥ threshold: spike_j=1, mem_j=0, ref_cnt_j=refractory_period.
  - Otherwise: spike_j=0, mem_j=clamped t.
- Neuron update, refractory case (ref_cnt_j≠0): ref_cnt_j−1, mem_j=0, spike_j=0.
- threshold=0 makes the neuron fire on every non-refractory update.
- enable low: FSM, idx, history and all registers hold their values. step and delay_tick are ignored.
- step is ignored outside IDLE. It is not queued.
- Reset at any time: all registers, including history and ref_cnt, go to 0 and the FSM returns to IDLE.

## Timing

- Reset values: membrane_potential_out=0, output_spikes=0, busy=0, output_data_ready=0.
- Step sampled high at the edge ending cycle T → RUN during cycles T+1..T+N_OUT.
- Neuron k's outputs update at the edge ending cycle T+1+k.
- output_data_ready is high during cycle T+N_OUT+1. It is always exactly one cycle wide.
- Minimum step-to-step spacing: N_OUT+2 cycles.
- A synapse with delay value d sees a spike that was sampled at tick n during the steps that fall between tick n+d and tick n+d+1.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure

- Shared package snn_pkg holds:
  - FSM state enum (IDLE, RUN, DONE)
  - weight bit-position constants (W_ACTIVE=0, W_INHIB=1)
  - function sat_update(mem, sum, decay) returning the clamped potential
- Sub-module snn_spike_history: one per input. Parameter DEPTH. Ports clk, reset, enable, delay_tick, spike_in, hist[DEPTH].
- The top module holds the snapshot registers, adder tree, per-neuron state, and FSM.

## Test plan

- Reset: drive reset mid-RUN at idx=3 → all outputs 0 next cycle, busy=0, and the next step restarts from neuron 0.
- LIF integrate/fire:
  - Setup: synapse (0,0) weight=01, no delay, threshold=3, decay=0, refractory=2, input_spikes=0x01.
  - 5 steps → mem0 = 1, 2, 0(spike), 0, 0.
  - 6th step → mem0=1, spike0=0.
- Delay:
  - Setup: synapse (0,0) delays field={1,3'd2}, weight=01, threshold=1.
  - Drive input=1 at tick 0, then 0. Issue a step after each tick.
  - Required: spike0=1 only after tick 2, and 0 for all other steps.
- Inhibition and clamp:
  - Setup: weight=11 on synapse (1,0), mem1=0, decay=3.
  - Step → mem1 stays 0.
  - Then preload mem1=2 via an excitatory path and apply decay=3 → mem1=0, with no negative wrap.
- Handshake:
  - step held high for N_OUT+2 cycles → exactly one output_data_ready pulse, at cycle T+9 (N_OUT=8).
  - A second step is accepted only after busy falls.
- Simultaneous events: step and delay_tick in the same cycle → the snapshot uses the pre-shift history. enable low for 4 cycles mid-RUN → idx and all outputs hold, and completion is delayed by exactly 4 cycles.
